multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Parametrised successor to the fixed five-strobe core controller/PC pair. It sequences one instruction at a time through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and owns the PC. It adds ready/wait-state handshakes to instruction and data memory, a wait-state timeout, branch target loading and a halt state. It sits between the instruction decoder and the regfile/alu/memory strobes in the core top.

Parameters:
PC_WIDTH, 10, width of pc; word-addressed.
RESET_PC, 0, pc value loaded on reset.
MEM_TIMEOUT, 15, max wait cycles on im_ready/dm_ready before error; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
is_load  in  1  decoded: instruction reads DM
is_store  in  1  decoded: instruction writes DM
is_branch  in  1  decoded: branch/jump, no writeback
branch_taken  in  1  branch condition true
branch_target  in  PC_WIDTH  target pc
halt  in  1  decoded halt instruction
im_ready  in  1  IM data valid this cycle
dm_ready  in  1  DM access complete this cycle
IM_enable, IM_read  out  1  IM access strobes
IM_write  out  1  IM write; tied 0
DM_enable, DM_read, DM_write  out  1  DM access strobes
enable_fetch  out  1  regfile operand read
enable_execute  out  1  alu execute
enable_writeback  out  1  regfile write
pc  out  PC_WIDTH  current instruction address
halted  out  1  in HALT state
mem_error  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst is high, all strobes, halted and mem_error are 0. On the reset edge, state becomes FETCH, pc becomes RESET_PC and the wait counter becomes 0.
- Outputs: strobes are decoded from the registered state only (Moore). Decoded inputs are sampled in DECODE, EXECUTE and MEM and must stay stable from DECODE until the instruction completes.
- FETCH: IM_enable=IM_read=1. On im_ready, go to DECODE. Otherwise stay and increment the wait counter.
- DECODE: enable_fetch=1 for one cycle. If halt, go to HALT; else go to EXECUTE.
- EXECUTE: enable_execute=1 for one cycle.
  - is_load or is_store: go to MEM.
  - is_branch: go to FETCH. pc <= branch_taken ? branch_target : pc+1.
  - otherwise: go to WRITEBACK.
- MEM: DM_enable=1, plus DM_read=is_load and DM_write=is_store. On dm_ready, a load goes to WRITEBACK; a store goes to FETCH with pc <= pc+1. Otherwise stay and count wait cycles.
- WRITEBACK: enable_writeback=1 for one cycle, then go to FETCH with pc <= pc+1.
- is_load and is_store both set: treated as load; DM_write=0.
- Latency with ready on the first cycle:
  - ALU op: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  Each wait cycle adds 1.
- Wait counter: cleared on entry to FETCH or MEM. If the counter equals MEM_TIMEOUT and ready is low, go to ERROR. If ready and the timeout coincide, ready wins.
- ERROR: all strobes 0. mem_error=1 and sticky until rst. pc holds. Exit only via rst.
- HALT: all strobes 0, halted=1, pc holds (points at the halt instruction). Exit only via rst.
- pc arithmetic is modulo 2^PC_WIDTH: all-ones + 1 wraps to 0.
- Reset mid-instruction, including mid-wait: the abort takes effect on that edge with no completion of the pending access. Strobes drop during the rst cycle.
- Exactly one of enable_fetch, enable_execute and enable_writeback is high in any cycle, or none is.

Optional Feature:
SEQ_STALL_COUNT_EN
- Defined: adds output stall_cycles[31:0], a saturating count of cycles spent in FETCH or MEM with ready low. It is cleared by rst and frozen in HALT/ERROR.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, ALU op, im_ready held high: strobes at cycles 1-4 are IM, fetch, execute, writeback. pc 0->1 at the end of cycle 4.
- Load with im_ready delayed 2 cycles and dm_ready delayed 1: 8 cycles total, DM_read=1 for 2 cycles, then writeback. With SEQ_STALL_COUNT_EN, stall_cycles=3.
- Branch, pc=5, branch_taken=1, target=0x3FF: next FETCH pc=0x3FF. The following ALU op wraps pc to 0.
- Store with dm_ready never asserted, MEM_TIMEOUT=15: after 15 wait cycles mem_error=1, all strobes 0, pc unchanged. rst clears it to pc=0.
- halt decoded at pc=7: halted=1 from the cycle after DECODE, no enable_execute, pc stays 7.
- rst asserted during a MEM wait: DM strobes drop that cycle; next cycle is FETCH at RESET_PC with mem_error=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with PC,
// memory ready handshakes, wait-state timeout and halt. Optional stall counter: SEQ_STALL_COUNT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// FETCH      | IM read in flight, waiting for im_ready
// DECODE     | regfile operand read, halt check
// EXECUTE    | alu cycle; branches resolve the next pc here
// MEM        | DM access in flight, waiting for dm_ready
// WRITEBACK  | regfile write, then advance pc
// HALT       | halt instruction decoded; parked until rst
// ERROR      | memory wait timed out; parked until rst
module multicycle_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int RESET_PC    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                is_branch,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt,
    input  logic                im_ready,
    input  logic                dm_ready,
    output logic                IM_enable,
    output logic                IM_read,
    output logic                IM_write,
    output logic                DM_enable,
    output logic                DM_read,
    output logic                DM_write,
    output logic                enable_fetch,
    output logic                enable_execute,
    output logic                enable_writeback,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                mem_error
`ifdef SEQ_STALL_COUNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(MEM_TIMEOUT);
    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;
    logic [CW-1:0]   wait_cnt_inc;
    logic [PC_WIDTH-1:0] pc_inc;

    assign timeout_hit  = TIMEOUT_EN && (wait_cnt == CNT_LIMIT);
    // With the timeout disabled the counter is never needed, so it stays parked at 0.
    assign wait_cnt_inc = TIMEOUT_EN ? (wait_cnt + CW'(1)) : wait_cnt;
    assign pc_inc       = pc + PC_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= PC_INIT;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (im_ready) begin
                        state <= S_DECODE;
                    end else if (timeout_hit) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end
                S_DECODE: begin
                    state <= halt ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (is_load || is_store) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                    end else if (is_branch) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                        pc       <= branch_taken ? branch_target : pc_inc;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (dm_ready) begin
                        if (is_load) begin
                            state <= S_WRITEBACK;
                        end else begin
                            state    <= S_FETCH;
                            wait_cnt <= '0;
                            pc       <= pc_inc;
                        end
                    end else if (timeout_hit) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end
                S_WRITEBACK: begin
                    state    <= S_FETCH;
                    wait_cnt <= '0;
                    pc       <= pc_inc;
                end
                S_HALT:  state <= S_HALT;
                S_ERROR: state <= S_ERROR;
                default: state <= S_ERROR;
            endcase
        end
    end

    // Strobes come from the registered state; rst masks them in the cycle it is asserted.
    always_comb begin
        IM_enable        = 1'b0;
        IM_read          = 1'b0;
        DM_enable        = 1'b0;
        DM_read          = 1'b0;
        DM_write         = 1'b0;
        enable_fetch     = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        halted           = 1'b0;
        mem_error        = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    IM_enable = 1'b1;
                    IM_read   = 1'b1;
                end
                S_DECODE:    enable_fetch = 1'b1;
                S_EXECUTE:   enable_execute = 1'b1;
                S_MEM: begin
                    DM_enable = 1'b1;
                    DM_read   = is_load;
                    DM_write  = is_store & ~is_load;
                end
                S_WRITEBACK: enable_writeback = 1'b1;
                S_HALT:      halted = 1'b1;
                S_ERROR:     mem_error = 1'b1;
                default: ;
            endcase
        end
    end

    assign IM_write = 1'b0;

`ifdef SEQ_STALL_COUNT_EN
    logic stalling;
    assign stalling = ((state == S_FETCH) && !im_ready) || ((state == S_MEM) && !dm_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stalling && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle vector table plus timeout/latency sequences.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_load, is_store, is_branch, branch_taken, halt, im_ready, dm_ready;
    logic [9:0] branch_target;
    logic       IM_enable, IM_read, IM_write, DM_enable, DM_read, DM_write;
    logic       enable_fetch, enable_execute, enable_writeback, halted, mem_error;
    logic [9:0] pc;
`ifdef SEQ_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    multicycle_sequencer #(.PC_WIDTH(10), .RESET_PC(0), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .enable_fetch(enable_fetch), .enable_execute(enable_execute),
        .enable_writeback(enable_writeback), .pc(pc), .halted(halted), .mem_error(mem_error)
`ifdef SEQ_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    // {IM_enable, IM_read, IM_write, DM_enable, DM_read, DM_write, fetch, execute, writeback, halted, mem_error}
    localparam logic [10:0] S_NONE = 11'h000;
    localparam logic [10:0] S_IM   = 11'h600;
    localparam logic [10:0] S_DMR  = 11'h0C0;
    localparam logic [10:0] S_DMW  = 11'h0A0;
    localparam logic [10:0] S_F    = 11'h010;
    localparam logic [10:0] S_X    = 11'h008;
    localparam logic [10:0] S_W    = 11'h004;
    localparam logic [10:0] S_HLT  = 11'h002;
    localparam logic [10:0] S_ERR  = 11'h001;

    logic [10:0] obs;
    assign obs = {IM_enable, IM_read, IM_write, DM_enable, DM_read, DM_write,
                  enable_fetch, enable_execute, enable_writeback, halted, mem_error};

    typedef struct {
        logic       r, ld, st, br, tk;
        logic [9:0] tgt;
        logic       hl, imr, dmr;
        logic [10:0] es;
        logic [9:0] ep;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad = 0;

    function automatic void add(input logic r, ld, st, br, tk, input logic [9:0] tg,
                                input logic hl, imr, dmr, input logic [10:0] es,
                                input logic [9:0] ep);
        vq.push_back('{r, ld, st, br, tk, tg, hl, imr, dmr, es, ep});
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, ld, st, br, tk, input logic [9:0] tg,
                         input logic hl, imr, dmr);
        rst = r; is_load = ld; is_store = st; is_branch = br; branch_taken = tk;
        branch_target = tg; halt = hl; im_ready = imr; dm_ready = dmr;
    endtask

    int err_cycle;
    int wb_cycle;
    int dmr_cnt;

    initial begin
        drive(1, 0, 0, 0, 0, 10'h0, 0, 0, 0);

        // reset state
        add(1,0,0,0,0,10'h000,0,0,0, S_NONE, 10'h000);
        // ALU op at pc 0, im_ready high: IM, fetch, execute, writeback
        add(0,0,0,0,0,10'h000,0,1,0, S_IM,  10'h000);
        add(0,0,0,0,0,10'h000,0,1,0, S_F,   10'h000);
        add(0,0,0,0,0,10'h000,0,1,0, S_X,   10'h000);
        add(0,0,0,0,0,10'h000,0,1,0, S_W,   10'h000);
        // load at pc 1: im_ready late by 2, dm_ready late by 1 -> 8 cycles
        add(0,1,0,0,0,10'h000,0,0,0, S_IM,  10'h001);
        add(0,1,0,0,0,10'h000,0,0,0, S_IM,  10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_IM,  10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_F,   10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_X,   10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_DMR, 10'h001);
        add(0,1,0,0,0,10'h000,0,1,1, S_DMR, 10'h001);
        add(0,1,0,0,0,10'h000,0,1,1, S_W,   10'h001);
        // store at pc 2, no waits: 4 cycles
        add(0,0,1,0,0,10'h000,0,1,1, S_IM,  10'h002);
        add(0,0,1,0,0,10'h000,0,1,1, S_F,   10'h002);
        add(0,0,1,0,0,10'h000,0,1,1, S_X,   10'h002);
        add(0,0,1,0,0,10'h000,0,1,1, S_DMW, 10'h002);
        // load+store at pc 3 behaves as load, DM_write stays 0
        add(0,1,1,0,0,10'h000,0,1,1, S_IM,  10'h003);
        add(0,1,1,0,0,10'h000,0,1,1, S_F,   10'h003);
        add(0,1,1,0,0,10'h000,0,1,1, S_X,   10'h003);
        add(0,1,1,0,0,10'h000,0,1,1, S_DMR, 10'h003);
        add(0,1,1,0,0,10'h000,0,1,1, S_W,   10'h003);
        // branch not taken at pc 4 -> pc 5
        add(0,0,0,1,0,10'h155,0,1,0, S_IM,  10'h004);
        add(0,0,0,1,0,10'h155,0,1,0, S_F,   10'h004);
        add(0,0,0,1,0,10'h155,0,1,0, S_X,   10'h004);
        // branch taken at pc 5 -> 0x3FF
        add(0,0,0,1,1,10'h3FF,0,1,0, S_IM,  10'h005);
        add(0,0,0,1,1,10'h3FF,0,1,0, S_F,   10'h005);
        add(0,0,0,1,1,10'h3FF,0,1,0, S_X,   10'h005);
        // ALU op at 0x3FF wraps pc to 0
        add(0,0,0,0,0,10'h000,0,1,0, S_IM,  10'h3FF);
        add(0,0,0,0,0,10'h000,0,1,0, S_F,   10'h3FF);
        add(0,0,0,0,0,10'h000,0,1,0, S_X,   10'h3FF);
        add(0,0,0,0,0,10'h000,0,1,0, S_W,   10'h3FF);
        // branch taken at pc 0 -> 7
        add(0,0,0,1,1,10'h007,0,1,0, S_IM,  10'h000);
        add(0,0,0,1,1,10'h007,0,1,0, S_F,   10'h000);
        add(0,0,0,1,1,10'h007,0,1,0, S_X,   10'h000);
        // halt at pc 7: no execute, pc stays, only rst leaves
        add(0,0,0,0,0,10'h000,1,1,0, S_IM,  10'h007);
        add(0,0,0,0,0,10'h000,1,1,0, S_F,   10'h007);
        add(0,0,0,0,0,10'h000,1,1,0, S_HLT, 10'h007);
        add(0,0,0,0,0,10'h000,0,1,1, S_HLT, 10'h007);
        add(1,0,0,0,0,10'h000,0,1,1, S_NONE,10'h007);
        // store with dm_ready never: 16 MEM cycles (counts 0..15), then ERROR
        add(0,0,1,0,0,10'h000,0,1,0, S_IM,  10'h000);
        add(0,0,1,0,0,10'h000,0,1,0, S_F,   10'h000);
        add(0,0,1,0,0,10'h000,0,1,0, S_X,   10'h000);
        for (int i = 0; i < 16; i++) add(0,0,1,0,0,10'h000,0,1,0, S_DMW, 10'h000);
        add(0,0,1,0,0,10'h000,0,1,0, S_ERR, 10'h000);
        add(0,0,1,0,0,10'h000,0,1,1, S_ERR, 10'h000);
        add(1,0,1,0,0,10'h000,0,1,1, S_NONE,10'h000);
        // ready coinciding with the timeout count wins
        add(0,0,1,0,0,10'h000,0,1,0, S_IM,  10'h000);
        add(0,0,1,0,0,10'h000,0,1,0, S_F,   10'h000);
        add(0,0,1,0,0,10'h000,0,1,0, S_X,   10'h000);
        for (int i = 0; i < 15; i++) add(0,0,1,0,0,10'h000,0,1,0, S_DMW, 10'h000);
        add(0,0,1,0,0,10'h000,0,1,1, S_DMW, 10'h000);
        // rst during a load's MEM wait: DM strobes drop that cycle, then FETCH at pc 0
        add(0,1,0,0,0,10'h000,0,1,0, S_IM,  10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_F,   10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_X,   10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_DMR, 10'h001);
        add(0,1,0,0,0,10'h000,0,1,0, S_DMR, 10'h001);
        add(1,1,0,0,0,10'h000,0,1,0, S_NONE,10'h001);
        add(0,0,0,0,0,10'h000,0,0,0, S_IM,  10'h000);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].r, vq[i].ld, vq[i].st, vq[i].br, vq[i].tk, vq[i].tgt,
                  vq[i].hl, vq[i].imr, vq[i].dmr);
            #1;
            check("strobes", i, 32'(obs), 32'(vq[i].es));
            check("pc", i, 32'(pc), 32'(vq[i].ep));
        end

        // timeout sequence: cycles 1-3 F/D/X, MEM cycles 4..19, mem_error first seen cycle 20
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 10'h0, 0, 0, 0);
        err_cycle = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 0, 10'h0, 0, 1, 0);
            #1;
            if (mem_error) begin
                err_cycle = c;
                break;
            end
        end
        check("timeout_cycle", 0, 32'(err_cycle), 32'd20);
        check("timeout_pc", 0, 32'(pc), 32'd0);
`ifdef SEQ_STALL_COUNT_EN
        check("stall_timeout", 0, stall_cycles, 32'd16);
        repeat (3) @(negedge clk);
        #1;
        check("stall_frozen", 0, stall_cycles, 32'd16);
`endif

        // load latency: im_ready from cycle 3, dm_ready from cycle 7, writeback on cycle 8
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 10'h0, 0, 0, 0);
        wb_cycle = -1;
        dmr_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 10'h0, 0, c >= 3, c >= 7);
            #1;
            if (DM_read) dmr_cnt++;
            if (enable_writeback && wb_cycle < 0) wb_cycle = c;
        end
        check("load_wb_cycle", 0, 32'(wb_cycle), 32'd8);
        check("load_dm_read_cycles", 0, 32'(dmr_cnt), 32'd2);
        check("load_next_pc", 0, 32'(pc), 32'd1);
`ifdef SEQ_STALL_COUNT_EN
        check("stall_load", 0, stall_cycles, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
